counter_gen: RTL

COUNTER_GEN -- requirements
Module: counter_gen

---
 rtl/counter_pkg.sv | 18 +
 rtl/counter_prescaler.sv | 36 +++
 rtl/counter_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and the per-edge operation type for the counter_gen block.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MODE_WRAP = 32'd0;
  localparam int unsigned MODE_SAT  = 32'd1;

  // Operation selected on an edge, already resolved by priority.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

endpackage

// File: rtl/counter_prescaler.sv
// Enabled-cycle prescaler: tick is high while the phase sits at PRESCALE-1.
module counter_prescaler #(
  parameter int unsigned PRESCALE = 32'd1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 32'd1) ? $clog2(PRESCALE) : 32'd1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 32'd1);

  logic [PW-1:0] phase_r;

  // Phase advances only on enabled cycles and restarts on clear or reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_r <= {PW{1'b0}};
    end else if (clr) begin
      phase_r <= {PW{1'b0}};
    end else if (en) begin
      if (phase_r == LAST) begin
        phase_r <= {PW{1'b0}};
      end else begin
        phase_r <= phase_r + PW'(1);
      end
    end else begin
      phase_r <= phase_r;
    end
  end

  assign tick = (phase_r == LAST);

endmodule

// File: rtl/counter_gen.sv
// Up/down counter with clamp-on-load, wrap or saturate at the boundary,
// prescaled stepping and a registered terminal-count pulse.
module counter_gen
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 32'd6,
  parameter int unsigned MAX      = 32'd63,
  parameter int unsigned SATURATE = 32'd0,
  parameter int unsigned PRESCALE = 32'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  // Reject parameter sets the counter cannot represent.
  if ((64'(MAX) >> WIDTH) != 64'd0) begin : g_bad_max
    $error("counter_gen: MAX does not fit in WIDTH bits");
  end
  if (PRESCALE < 32'd1 || PRESCALE > 32'd256) begin : g_bad_prescale
    $error("counter_gen: PRESCALE must be 1..256");
  end
  if (WIDTH < 32'd2 || WIDTH > 32'd32) begin : g_bad_width
    $error("counter_gen: WIDTH must be 2..32");
  end

  localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];
  localparam logic             SAT   = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] cnt_r;
  logic             tc_r;
  logic [WIDTH-1:0] cnt_next_s;
  logic             tc_next_s;
  logic             tick_s;
  logic             at_bound_s;
  op_e              op_s;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clr   (clr | load),
    .tick  (tick_s)
  );

  // Resolve the edge's operation by priority and detect the boundary for the current direction.
  always_comb begin
    op_s = OP_HOLD;
    if (clr) begin
      op_s = OP_CLR;
    end else if (load) begin
      op_s = OP_LOAD;
    end else if (cnt_en && tick_s) begin
      op_s = OP_STEP;
    end else begin
      op_s = OP_HOLD;
    end
    if (dir == DIR_UP) begin
      at_bound_s = (cnt_r == MAX_V);
    end else begin
      at_bound_s = (cnt_r == {WIDTH{1'b0}});
    end
  end

  // Next count and terminal-count pulse; a boundary step either wraps or holds.
  always_comb begin
    cnt_next_s = cnt_r;
    tc_next_s  = 1'b0;
    case (op_s)
      OP_CLR:  cnt_next_s = {WIDTH{1'b0}};
      OP_LOAD: cnt_next_s = (load_val > MAX_V) ? MAX_V : load_val;
      OP_STEP: begin
        tc_next_s = at_bound_s;
        if (at_bound_s) begin
          if (SAT) begin
            cnt_next_s = cnt_r;
          end else begin
            cnt_next_s = (dir == DIR_UP) ? {WIDTH{1'b0}} : MAX_V;
          end
        end else begin
          cnt_next_s = (dir == DIR_UP) ? (cnt_r + WIDTH'(1)) : (cnt_r - WIDTH'(1));
        end
      end
      default: cnt_next_s = cnt_r;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= {WIDTH{1'b0}};
      tc_r  <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      tc_r  <= tc_next_s;
    end
  end

  assign cnt = cnt_r;
  assign tc  = tc_r;

endmodule
